// File: rtl/issue_dispatch.sv
// MPU-to-TPU issue transmitter: buffers issue requests in a ring FIFO and
// broadcasts the head entry to every enabled TPU until each one has acked it.
module issue_dispatch #(
  parameter int NUM_TPU   = 1,
  parameter int BUFF_SIZE = 4,
  parameter int WIDTH_NO  = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        I_Req,
  input  logic [WIDTH_NO-1:0]         I_Issue_No,
  input  logic [NUM_TPU-1:0]          I_En_TPU,
  output logic                        O_Ack,
  input  logic                        I_Agg_Full,
  output logic                        O_Agg_Req,
  output logic [WIDTH_NO-1:0]         O_Agg_Issue_No,
  output logic [NUM_TPU-1:0]          O_Agg_En_TPU,
  output logic [NUM_TPU-1:0]          O_Issue_Req,
  output logic [WIDTH_NO-1:0]         O_Issue_No,
  input  logic [NUM_TPU-1:0]          I_Issue_Ack,
  output logic                        O_Full,
  output logic                        O_Empty,
  output logic [$clog2(BUFF_SIZE):0]  O_Num
);

  localparam int PTR_W = $clog2(BUFF_SIZE);
  localparam int NUM_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  logic [WIDTH_NO-1:0] fifo_no [BUFF_SIZE];
  logic [NUM_TPU-1:0]  fifo_en [BUFF_SIZE];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [NUM_W-1:0]    num;
  logic [NUM_W-1:0]    num_nxt;
  state_t              state;
  state_t              state_nxt;
  logic [NUM_TPU-1:0]  pending;
  logic [NUM_TPU-1:0]  pending_nxt;
  logic [WIDTH_NO-1:0] cur_no;
  logic                accept;
  logic                pop;

  // Acceptance never bypasses a same-cycle pop: a full FIFO refuses outright.
  assign O_Full         = (num == NUM_W'(BUFF_SIZE));
  assign O_Empty        = (num == '0);
  assign O_Num          = num;
  assign accept         = I_Req & ~O_Full & ~I_Agg_Full & ~reset;
  assign O_Ack          = accept;
  assign O_Agg_Req      = accept;
  assign O_Agg_Issue_No = I_Issue_No;
  assign O_Agg_En_TPU   = I_En_TPU;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    pop         = 1'b0;
    O_Issue_Req = '0;
    O_Issue_No  = '0;
    case (state)
      LOAD: pending_nxt = fifo_en[rd_ptr];
      SEND: begin
        O_Issue_Req = pending;
        O_Issue_No  = cur_no;
        pending_nxt = pending & ~I_Issue_Ack;
        pop         = (pending_nxt == '0);
      end
      default: ;
    endcase
    num_nxt = num + NUM_W'(accept) - NUM_W'(pop);
    // Entering LOAD on the post-edge count lets a fresh entry load right away.
    case (state)
      IDLE:    if (num_nxt != '0) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (pop) state_nxt = (num_nxt != '0) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      num     <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      num     <= num_nxt;
      pending <= pending_nxt;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage and the latched issue number carry no reset; control gates them.
  always_ff @(posedge clock) begin
    if (accept) begin
      fifo_no[wr_ptr] <= I_Issue_No;
      fifo_en[wr_ptr] <= I_En_TPU;
    end
    if (state == LOAD) cur_no <= fifo_no[rd_ptr];
  end

endmodule

// File: doc/issue_dispatch.md
# issue_dispatch

- Transmitter side of the MPU→TPU issue/commit protocol.
- Accepts issue requests from the MPU, each an issue number plus a TPU enable mask, and buffers them in a ring FIFO.
- Broadcasts the head entry to every enabled TPU with a per-TPU valid/ack handshake.
- On acceptance, registers each issue with the commit aggregator so that the TPU commits coming back can be matched.

## Interface
- NUM_TPU, 1, number of TPUs driven
- BUFF_SIZE, 4, FIFO entries; power of two, ≥2
- WIDTH_NO, 8, issue number width; equals width of mpu_issue_no_t

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- I_Req  in  1  issue request from MPU
- I_Issue_No  in  WIDTH_NO  issue number
- I_En_TPU  in  NUM_TPU  target TPU mask
- O_Ack  out  1  request accepted this cycle
- I_Agg_Full  in  1  commit aggregator full
- O_Agg_Req  out  1  register issue with aggregator
- O_Agg_Issue_No  out  WIDTH_NO  issue number to aggregator
- O_Agg_En_TPU  out  NUM_TPU  mask to aggregator
- O_Issue_Req  out  NUM_TPU  per-TPU issue valid
- O_Issue_No  out  WIDTH_NO  broadcast issue number (head entry)
- I_Issue_Ack  in  NUM_TPU  per-TPU issue accept
- O_Full  out  1  FIFO full
- O_Empty  out  1  FIFO empty
- O_Num  out  $clog2(BUFF_SIZE)+1  valid entry count

## Operation
- Accept = I_Req & ~O_Full & ~I_Agg_Full; combinational.
  - O_Ack = Accept.
  - O_Agg_Req = Accept.
  - O_Agg_Issue_No = I_Issue_No; O_Agg_En_TPU = I_En_TPU (pass-through).
- On Accept, {I_Issue_No, I_En_TPU} is written at Wr_Ptr and Wr_Ptr increments modulo BUFF_SIZE.
- A rejected request is dropped; the MPU holds I_Req until it sees O_Ack.
- Dispatch FSM:
  - IDLE: FIFO empty; no requests driven. Go to LOAD when O_Num≠0.
  - LOAD: latch head entry into Pending (NUM_TPU mask) and Cur_No. Go to SEND.
  - SEND: O_Issue_Req = Pending; O_Issue_No = Cur_No.
    - At each edge, Pending[j] clears when O_Issue_Req[j] & I_Issue_Ack[j].
    - When the next value of Pending is 0: pop the head (Rd_Ptr+1 mod BUFF_SIZE), then go to LOAD if the post-pop count is ≠0, else IDLE.
- Mask 0 entry: LOAD gives Pending=0; SEND lasts one cycle with no requests, then pops. It is still forwarded to the aggregator.
- TPUs may ack in any order and in any cycle. Ack while O_Issue_Req[j]=0 is ignored.
- O_Issue_Req[j] stays high until acked; there is no timeout.
- O_Issue_No is 0 outside SEND.
- Push and pop in the same edge: O_Num unchanged, both pointers advance.
- O_Full = (O_Num==BUFF_SIZE); O_Empty = (O_Num==0).

## Timing
- Reset values:
  - O_Issue_Req=0, O_Issue_No=0, O_Full=0, O_Empty=1, O_Num=0.
  - Pointers 0, Pending=0, state IDLE.
  - O_Ack, O_Agg_Req follow inputs combinationally but are forced 0 while reset=1.
- Reset mid-operation discards all entries and pending requests; O_Issue_Req=0 from the next cycle.
- Latency:
  - Accept at cycle t into an empty FIFO: LOAD at t+1, O_Issue_Req visible at t+2.
  - Minimum occupancy per entry is 2 cycles (LOAD+SEND), so peak throughput is 1 entry per 2 cycles.
- Acked in the first SEND cycle: the next entry's LOAD follows immediately, and its O_Issue_Req appears 2 cycles after the previous one.
- Full: accept is blocked at O_Num==BUFF_SIZE. An accept is allowed in a cycle where a pop also occurs only if O_Full was 0 that cycle; no bypass.
- I_Agg_Full=1 blocks accept regardless of FIFO state.

## Test plan
- Single issue, NUM_TPU=4:
  - Req no=0x05, mask=4'b1011 at t0 → O_Ack=1 and O_Agg_Req=1 at t0.
  - O_Issue_Req=4'b1011 and O_Issue_No=0x05 at t0+2.
  - Ack TPU0 at t0+2, TPU3 at t0+4, TPU1 at t0+5 → Pending reads 1010, 0010, then 0; FIFO empty and IDLE at t0+6.
- Fill: BUFF_SIZE=4, 5 back-to-back requests 0x10..0x14, no acks → first 4 accepted; O_Full=1, O_Num=4; 5th gets O_Ack=0 and O_Agg_Req=0.
- Wrap-around: stream 10 issues with immediate all-ones ack → issue numbers appear in order; pointers wrap; O_Num never exceeds 4; each entry holds requests for 1 cycle.
- Aggregator backpressure: I_Agg_Full=1 with I_Req=1, FIFO empty → O_Ack=0, no write. Drop I_Agg_Full → accepted the same cycle.
- Zero mask: issue 0x22 with mask 0, then 0x23 with mask 0001 → 0x22 produces no O_Issue_Req but pops after one SEND cycle; 0x23 is requested 2 cycles after that.
- Reset mid-operation: 3 entries queued, SEND active on TPU2 → reset pulse gives O_Issue_Req=0, O_Empty=1, O_Num=0; a new request after reset is dispatched normally.
